mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main control unit for the 5-bit-opcode MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath select/enable line as a Moore decode of its state register. Stalls on a shared instruction/data memory via a ready handshake, and keeps a retired-instruction counter for debug.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Op`  in  5  opcode field of the instruction register
- `zero`  in  1  ALU zero flag (valid in EXEC)
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_read`, `mem_write`, `iord`  out  1 each  memory strobe/address select (0 = PC, 1 = ALUOut)
- `ir_write`, `pc_write`, `pc_write_cond`  out  1 each  register enables
- `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a`  out  1 each  register-file and ALU selects
- `alu_src_b`  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
- `alu_op`  out  2  0 = add, 1 = sub, 2 = funct-decoded
- `pc_src`  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `illegal_op`  out  1  sticky flag, set on undefined opcode
- `halted`  out  1  high in HALT
- `instr_count`  out  CNT_W  retired instructions, wraps mod 2^CNT_W
- `state`  out  4  current state encoding (debug)

## Operation
- Opcodes: RTYPE=0x00, LW=0x01, SW=0x02, BEQ=0x03, ADDI=0x04, J=0x05, HALT=0x1F. All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT.
- IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0.
  - Holds until `mem_ready`.
  - In the ready cycle: `ir_write`=1, `pc_write`=1, `pc_src`=0, next state DECODE.
- DECODE: `alu_src_b`=3 (branch-target precompute).
  - Dispatch on `Op`: RTYPE→EXEC_R; LW/SW→ADDR; ADDI→EXEC_I; BEQ→BRANCH; J→JUMP; HALT→HALT.
  - Illegal → FETCH, with `illegal_op` set and `instr_done` pulsed.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2 → WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0 → WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0 → FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=2 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then → WB_MEM.
- MEM_WR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then → FETCH.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`=1, `pc_src`=1 → FETCH. The datapath gates the PC write with `zero`.
- JUMP: `pc_write`=1, `pc_src`=2 → FETCH.
- HALT: terminal; only `halted`=1. Exited only by `rst`.
- `instr_done` pulses in the final state of every instruction: WB_R, WB_I, WB_MEM, MEM_WR ready cycle, BRANCH, JUMP, illegal DECODE, and the entry cycle of HALT.
- `instr_count` increments on each `instr_done`.
- Outputs not listed for a state are 0.

## Timing
- Reset: asynchronous. State = IDLE; `instr_count`=0; `illegal_op`=0; every output 0 while `rst` is high.
- First FETCH occurs in the second cycle after `rst` deasserts.
- Cycles per instruction with `mem_ready` tied high: RTYPE 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Each low cycle of `mem_ready` in FETCH/MEM_RD/MEM_WR adds one cycle. All strobes stay stable during the stall.
- `Op` is sampled only in DECODE. `mem_ready` is ignored outside memory states.
- Counter rolls from 2^CNT_W−1 to 0 without a flag.
- `rst` mid-instruction aborts immediately. No partial strobe survives the asynchronous assertion.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode localparams;
  - state enum (4-bit encoding);
  - `alu_src_b`, `alu_op` and `pc_src` encodings.
- Single module: state register, next-state logic, output decode, counter.
- No sub-module.

## Test plan
- Reset, then Op=0x00 with `mem_ready`=1 → states IDLE, FETCH, DECODE, EXEC_R, WB_R. `reg_write`=1 only in WB_R. `instr_count`=1.
- LW with `mem_ready` low for 3 cycles in MEM_RD → `mem_read`=1, `iord`=1 held 4 cycles. Total 8 cycles; `mem_to_reg`=1 in WB_MEM.
- BEQ then J back-to-back → `pc_write_cond`=1 with `pc_src`=1, then `pc_write`=1 with `pc_src`=2. 6 cycles total; count +2.
- Op=0x0A → `illegal_op`=1 sticky. FETCH follows DECODE; `instr_done` pulses.
- Preload 0xFFFF retirements, then one ADDI → `instr_count`=0x0000.
- HALT, then assert `rst` mid-MEM_WR of a later run → `halted`=1 until reset. All outputs are 0 in the same cycle `rst` rises.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// opcodes, FSM state encoding and datapath select values.
package mips_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'h00;
  localparam logic [4:0] OP_LW    = 5'h01;
  localparam logic [4:0] OP_SW    = 5'h02;
  localparam logic [4:0] OP_BEQ   = 5'h03;
  localparam logic [4:0] OP_ADDI  = 5'h04;
  localparam logic [4:0] OP_J     = 5'h05;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// decodes datapath strobes from the state register and counts retired instructions.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_store;
  logic             r_halt_entry;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_op_legal;
  logic             w_unused_zero;

  // The branch decision is made in the datapath (zero gates pc_write_cond).
  assign w_unused_zero = zero;
  assign w_op_legal    = op_is_legal(Op);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_ADDR;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_HALT:      w_next = S_HALT;
          default:      w_next = S_FETCH;
        endcase
      end
      S_EXEC_R: w_next = S_WB_R;
      S_EXEC_I: w_next = S_WB_I;
      S_ADDR:   w_next = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) w_next = S_WB_MEM;
      S_MEM_WR: if (mem_ready) w_next = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    instr_done    = 1'b0;
    halted        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        instr_done = !w_op_legal;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted     = 1'b1;
        instr_done = r_halt_entry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_halt_entry <= 1'b0;
      r_illegal    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_next;
      // HALT retires only on its entry cycle, so remember that we just arrived.
      r_halt_entry <= (r_state == S_DECODE) && (Op == OP_HALT);
      if (r_state == S_DECODE) begin
        r_is_store <= (Op == OP_SW);
        if (!w_op_legal) r_illegal <= 1'b1;
      end
      if (instr_done) r_count <= r_count + CNT_W'(1);
    end
  end

  assign illegal_op  = r_illegal;
  assign instr_count = r_count;
  assign state       = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-instruction phase model builds an expected
// cycle queue, which is replayed against the DUT and compared every cycle.
module tb_mc_control_fsm;
  import mips_ctrl_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    Op = 5'h00;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic          instr_done, illegal_op, halted;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .halted(halted),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic mrd, mwr, iord, irw, pcw, pcwc, rw, rdst, m2r, asa;
    logic [1:0] asb, aop, psrc;
    logic done, ill, halt;
  } ov_t;

  typedef struct {
    logic          mr;
    logic [4:0]    op;
    ov_t           o;
    logic [CW-1:0] cnt;
    string         tag;
  } cyc_t;

  cyc_t          q[$];
  logic [CW-1:0] m_count;
  logic          m_ill;
  string         cur_tag;
  int            checks = 0;
  int            passed = 0;
  int            cyc_no = 0;

  function automatic ov_t blank(input state_t s);
    ov_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic ov_t actual();
    ov_t a;
    a.st = state;  a.mrd = mem_read;  a.mwr = mem_write;  a.iord = iord;
    a.irw = ir_write;  a.pcw = pc_write;  a.pcwc = pc_write_cond;
    a.rw = reg_write;  a.rdst = reg_dst;  a.m2r = mem_to_reg;  a.asa = alu_src_a;
    a.asb = alu_src_b;  a.aop = alu_op;  a.psrc = pc_src;
    a.done = instr_done;  a.ill = illegal_op;  a.halt = halted;
    return a;
  endfunction

  function automatic logic [4:0] r_op();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic r_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected count/illegal flag are the values before this cycle's edge.
  task automatic push(input ov_t o, input logic mr, input logic [4:0] op);
    cyc_t c;
    o.ill = m_ill;
    c.mr = mr;  c.op = op;  c.o = o;  c.cnt = m_count;  c.tag = cur_tag;
    q.push_back(c);
    if (o.done) m_count = m_count + 1'b1;
  endtask

  task automatic p_fetch(input int stall);
    ov_t o;
    o = blank(S_FETCH);
    o.mrd = 1'b1;  o.asb = 2'd1;
    for (int i = 0; i < stall; i++) push(o, 1'b0, r_op());
    o.irw = 1'b1;  o.pcw = 1'b1;
    push(o, 1'b1, r_op());
  endtask

  task automatic p_decode(input logic [4:0] op);
    ov_t  o;
    logic legal;
    legal = (op <= 5'h05) || (op == 5'h1F);
    o = blank(S_DECODE);
    o.asb = 2'd3;
    o.done = !legal;
    push(o, r_bit(), op);
    if (!legal) m_ill = 1'b1;
  endtask

  task automatic p_halt(input int n);
    ov_t o;
    o = blank(S_HALT);
    o.halt = 1'b1;
    for (int i = 0; i < n; i++) push(o, r_bit(), r_op());
  endtask

  // Appends the cycles of one instruction; trunc leaves a SW stuck in MEM_WR.
  task automatic instr(input string tag, input logic [4:0] op, input int f_stall,
                       input int m_stall, input bit trunc, output int ncyc);
    ov_t o;
    int  start;
    start = q.size();
    cur_tag = tag;
    p_fetch(f_stall);
    p_decode(op);
    case (op)
      OP_RTYPE: begin
        o = blank(S_EXEC_R);  o.asa = 1;  o.aop = 2'd2;  push(o, r_bit(), r_op());
        o = blank(S_WB_R);  o.rw = 1;  o.rdst = 1;  o.done = 1;  push(o, r_bit(), r_op());
      end
      OP_ADDI: begin
        o = blank(S_EXEC_I);  o.asa = 1;  o.asb = 2'd2;  push(o, r_bit(), r_op());
        o = blank(S_WB_I);  o.rw = 1;  o.done = 1;  push(o, r_bit(), r_op());
      end
      OP_LW: begin
        o = blank(S_ADDR);  o.asa = 1;  o.asb = 2'd2;  push(o, r_bit(), r_op());
        o = blank(S_MEM_RD);  o.mrd = 1;  o.iord = 1;
        for (int i = 0; i < m_stall; i++) push(o, 1'b0, r_op());
        push(o, 1'b1, r_op());
        o = blank(S_WB_MEM);  o.rw = 1;  o.m2r = 1;  o.done = 1;  push(o, r_bit(), r_op());
      end
      OP_SW: begin
        o = blank(S_ADDR);  o.asa = 1;  o.asb = 2'd2;  push(o, r_bit(), r_op());
        o = blank(S_MEM_WR);  o.mwr = 1;  o.iord = 1;
        for (int i = 0; i < m_stall; i++) push(o, 1'b0, r_op());
        if (!trunc) begin
          o.done = 1;
          push(o, 1'b1, r_op());
        end
      end
      OP_BEQ: begin
        o = blank(S_BRANCH);  o.asa = 1;  o.aop = 2'd1;  o.pcwc = 1;  o.psrc = 2'd1;
        o.done = 1;  push(o, r_bit(), r_op());
      end
      OP_J: begin
        o = blank(S_JUMP);  o.pcw = 1;  o.psrc = 2'd2;  o.done = 1;  push(o, r_bit(), r_op());
      end
      OP_HALT: begin
        o = blank(S_HALT);  o.halt = 1;  o.done = 1;  push(o, r_bit(), r_op());
      end
      default: ;
    endcase
    ncyc = q.size() - start;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Called at posedge+1; replays each queued cycle and compares at the falling edge.
  task automatic run_queue();
    cyc_t c;
    ov_t  a;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.mr;
      Op = c.op;
      @(negedge clk);
      a = actual();
      checks++;
      if (a === c.o && instr_count === c.cnt) passed++;
      else $display("FAIL %s cyc%0d: got outs=%h cnt=%0d expected outs=%h cnt=%0d",
                    c.tag, cyc_no, a, instr_count, c.o, c.cnt);
      cyc_no++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    Op = r_op();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({actual(), instr_count}), 32'({blank(S_IDLE), {CW{1'b0}}}));
    rst = 1'b0;
    m_count = '0;
    m_ill = 1'b0;
    cur_tag = "idle";
    push(blank(S_IDLE), r_bit(), r_op());
  endtask

  initial begin
    int n, n2;

    // Segment A: every opcode, stalls, illegal, then HALT.
    do_reset();
    instr("rtype", OP_RTYPE, 0, 0, 1'b0, n);   check("cpi_rtype", n, 4);
    instr("lw_stall", OP_LW, 0, 3, 1'b0, n);   check("cpi_lw_stall", n, 8);
    instr("beq", OP_BEQ, 0, 0, 1'b0, n);
    instr("j", OP_J, 0, 0, 1'b0, n2);          check("cpi_beq_j", n + n2, 6);
    instr("illegal", 5'h0A, 0, 0, 1'b0, n);    check("cpi_illegal", n, 2);
    instr("addi", OP_ADDI, 0, 0, 1'b0, n);     check("cpi_addi", n, 4);
    instr("sw_stall", OP_SW, 2, 1, 1'b0, n);   check("cpi_sw_stall", n, 7);
    instr("lw", OP_LW, 0, 0, 1'b0, n);         check("cpi_lw", n, 5);
    instr("halt", OP_HALT, 0, 0, 1'b0, n);     check("cpi_halt", n, 3);
    cur_tag = "halt_hold";
    p_halt(6);
    run_queue();
    check("halt_state", state, S_HALT);
    check("halted", halted, 1);
    check("illegal_sticky", illegal_op, 1);
    check("count_seg_a", instr_count, 9);

    // Segment B: async reset in the middle of a stalled store.
    do_reset();
    instr("rtype_b", OP_RTYPE, 0, 0, 1'b0, n);
    instr("sw_abort", OP_SW, 0, 2, 1'b1, n);
    run_queue();
    check("memwr_held", {state, mem_write, iord}, {S_MEM_WR, 1'b1, 1'b1});
    check("count_before_abort", instr_count, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_outs", 32'({actual(), instr_count}), 32'({blank(S_IDLE), {CW{1'b0}}}));

    // Segment C: counter rollover after 2^CW retirements.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) instr("ill_fill", 5'(6 + (i % 25)), 0, 0, 1'b0, n);
    instr("addi_wrap", OP_ADDI, 0, 0, 1'b0, n);
    run_queue();
    check("wrap_count", instr_count, 0);
    check("wrap_state", state, S_FETCH);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
